// File: rtl/rob_pkg.sv
// Shared types for the superscalar reorder buffer: entry layout, pointer type and sizing helper.
// Optional macro ROB_EXCEPTION_EN adds a per-entry exception bit.
package rob_pkg;

  localparam int ROB_WIDTH_DEF  = 4;
  localparam int PREG_WIDTH_DEF = 7;

  // Head/tail pointer: index bits plus one wrap bit.
  typedef logic [ROB_WIDTH_DEF:0] rob_ptr_t;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      is_branch;
    logic                      reg_write;
    logic [PREG_WIDTH_DEF-1:0] old_prd;
    logic [31:0]               pc;
`ifdef ROB_EXCEPTION_EN
    logic                      exc;
`endif
  } rob_entry_t;

  function automatic int rob_size(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Prefix-AND over the head window: a lane retires only if every older lane retires too.
// A solo request (exception at head) restricts retirement to lane 0.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2
) (
  input  logic [COMMIT_WIDTH-1:0]          lane_ok,
  input  logic                             solo,
  output logic [COMMIT_WIDTH-1:0]          commit_valid,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_cnt
);

  logic [COMMIT_WIDTH:0] chain;

  assign chain[0] = 1'b1;

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane
    assign chain[gi+1]      = chain[gi] && lane_ok[gi] && ((gi == 0) || !solo);
    assign commit_valid[gi] = chain[gi+1];
  end

  assign commit_cnt = ($clog2(COMMIT_WIDTH+1))'($countones(commit_valid));

endmodule

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: multi-lane allocation, CDB completion, in-order multi-lane commit
// and partial flush on mispredict. Macro ROB_EXCEPTION_EN adds precise-exception flush.
module rob_superscalar
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH      = 4,
  parameter int PREG_WIDTH     = 7,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMMIT_WIDTH   = 2,
  parameter int CDB_PORTS      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DISPATCH_WIDTH-1:0]           i_alloc_valid,
  input  logic [DISPATCH_WIDTH*PREG_WIDTH-1:0] i_old_prd,
  input  logic [DISPATCH_WIDTH-1:0]           i_reg_write,
  input  logic [DISPATCH_WIDTH-1:0]           i_is_branch,
  input  logic [DISPATCH_WIDTH*32-1:0]        i_pc,
  output logic                                o_alloc_ready,
  output logic [DISPATCH_WIDTH*ROB_WIDTH-1:0] o_alloc_tag,
  input  logic [CDB_PORTS-1:0]                i_cdb_valid,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0]      i_cdb_tag,
`ifdef ROB_EXCEPTION_EN
  input  logic [CDB_PORTS-1:0]                i_cdb_exc,
  output logic                                o_exception,
  output logic [31:0]                         o_exception_pc,
`endif
  output logic [COMMIT_WIDTH-1:0]             o_commit_valid,
  output logic [COMMIT_WIDTH*PREG_WIDTH-1:0]  o_commit_old_preg,
  output logic [COMMIT_WIDTH*ROB_WIDTH-1:0]   o_commit_tag,
  output logic [ROB_WIDTH:0]                  o_count,
  input  logic                                i_mispredict,
  input  logic [ROB_WIDTH-1:0]                i_mispredict_tag
);

  localparam int ROB_SIZE = rob_size(ROB_WIDTH);
  localparam int PW       = ROB_WIDTH + 1;
  localparam int ACW      = $clog2(DISPATCH_WIDTH + 1);
  localparam int CCW      = $clog2(COMMIT_WIDTH + 1);
  localparam int LW       = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  rob_entry_t entries_reg  [ROB_SIZE];
  rob_entry_t entries_next [ROB_SIZE];

  logic [PW-1:0]           head_reg, tail_reg, head_next, tail_next, count;
  logic [ROB_WIDTH-1:0]    head_idx, tail_idx, br_off;
  logic                    alloc_fire, solo;
  logic [ACW-1:0]          n_alloc;
  logic [CCW-1:0]          n_commit;
  logic [COMMIT_WIDTH-1:0] lane_ok;

  assign count         = tail_reg - head_reg;
  assign head_idx      = head_reg[ROB_WIDTH-1:0];
  assign tail_idx      = tail_reg[ROB_WIDTH-1:0];
  assign o_count       = count;
  assign o_alloc_ready = count <= PW'(ROB_SIZE - DISPATCH_WIDTH);
  assign alloc_fire    = o_alloc_ready && !i_mispredict;
  assign n_alloc       = ACW'($countones(i_alloc_valid));
  // Distance of the mispredicting branch from head; everything beyond it is wrong-path.
  assign br_off        = i_mispredict_tag - head_idx;

  for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_alloc_tag
    assign o_alloc_tag[gi*ROB_WIDTH +: ROB_WIDTH] = tail_idx + ROB_WIDTH'(gi);
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit
    logic [ROB_WIDTH-1:0] idx;
    logic                 exc_blk;
    assign idx = head_idx + ROB_WIDTH'(gi);
`ifdef ROB_EXCEPTION_EN
    assign exc_blk = (gi != 0) && entries_reg[idx].exc;
`else
    assign exc_blk = 1'b0;
`endif
    assign lane_ok[gi] = (PW'(gi) < count) && entries_reg[idx].valid && entries_reg[idx].done
                         && (!i_mispredict || (ROB_WIDTH'(gi) <= br_off)) && !exc_blk;
    assign o_commit_tag[gi*ROB_WIDTH +: ROB_WIDTH] = idx;
    assign o_commit_old_preg[gi*PREG_WIDTH +: PREG_WIDTH] =
      entries_reg[idx].reg_write ? entries_reg[idx].old_prd : '0;
  end

`ifdef ROB_EXCEPTION_EN
  assign solo           = lane_ok[0] && entries_reg[head_idx].exc;
  assign o_exception    = solo;
  assign o_exception_pc = entries_reg[head_idx].pc;
`else
  assign solo = 1'b0;
`endif

  rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_commit_select (
    .lane_ok      (lane_ok),
    .solo         (solo),
    .commit_valid (o_commit_valid),
    .commit_cnt   (n_commit)
  );

  for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
    logic [ROB_WIDTH-1:0] off_h, off_t;
    logic [LW-1:0]        lane;
    logic                 retire, flush, alloc_hit, cdb_hit, cdb_exc;
    rob_entry_t           nxt;

    assign off_h     = ROB_WIDTH'(gi) - head_idx;
    assign off_t     = ROB_WIDTH'(gi) - tail_idx;
    assign lane      = LW'(off_t);
    assign retire    = PW'(off_h) < PW'(n_commit);
    assign flush     = i_mispredict && (off_h > br_off) && (PW'(off_h) < count);
    assign alloc_hit = alloc_fire && (PW'(off_t) < PW'(n_alloc));

    always_comb begin
      cdb_hit = 1'b0;
      cdb_exc = 1'b0;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (i_cdb_valid[p] && (i_cdb_tag[p*ROB_WIDTH +: ROB_WIDTH] == ROB_WIDTH'(gi))) begin
          cdb_hit = 1'b1;
`ifdef ROB_EXCEPTION_EN
          cdb_exc = cdb_exc | i_cdb_exc[p];
`endif
        end
      end
    end

    always_comb begin
      nxt = entries_reg[gi];
      if (solo) begin
        nxt = '0;
      end else if (alloc_hit) begin
        nxt           = '0;
        nxt.valid     = 1'b1;
        nxt.is_branch = i_is_branch[lane];
        nxt.reg_write = i_reg_write[lane];
        nxt.old_prd   = i_old_prd[lane*PREG_WIDTH +: PREG_WIDTH];
        nxt.pc        = i_pc[lane*32 +: 32];
      end else if (retire || flush) begin
        nxt = '0;
      end else if (cdb_hit && entries_reg[gi].valid) begin
        nxt.done = 1'b1;
`ifdef ROB_EXCEPTION_EN
        nxt.exc  = entries_reg[gi].exc | cdb_exc;
`endif
      end
    end

    assign entries_next[gi] = nxt;
  end

  always_comb begin
    head_next = head_reg + PW'(n_commit);
    tail_next = tail_reg;
    if (i_mispredict) begin
      tail_next = head_reg + PW'(br_off) + PW'(1);
    end else if (alloc_fire) begin
      tail_next = tail_reg + PW'(n_alloc);
    end
    if (solo) begin
      head_next = '0;
      tail_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      entries_reg <= '{default: '0};
    end else begin
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      entries_reg <= entries_next;
    end
  end

  // Branch flag and PC are carried for downstream debug/recovery but not consumed here.
  logic unused_payload;
  always_comb begin
    unused_payload = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      unused_payload = unused_payload ^ (^{entries_reg[i].pc, entries_reg[i].is_branch});
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for rob_superscalar at default parameters (16 entries, 2-wide).
`timescale 1ns/1ps
module tb_rob_superscalar;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  alloc_valid, reg_write, is_branch;
  logic [13:0] old_prd;
  logic [63:0] pc;
  logic        alloc_ready;
  logic [7:0]  alloc_tag;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [1:0]  commit_valid;
  logic [13:0] commit_old_preg;
  logic [7:0]  commit_tag;
  logic [4:0]  count;
  logic        mispredict;
  logic [3:0]  mispredict_tag;
`ifdef ROB_EXCEPTION_EN
  logic [1:0]  cdb_exc = 2'b00;
  logic        exception;
  logic [31:0] exception_pc;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rob_superscalar dut (
    .clk               (clk),
    .reset             (reset),
    .i_alloc_valid     (alloc_valid),
    .i_old_prd         (old_prd),
    .i_reg_write       (reg_write),
    .i_is_branch       (is_branch),
    .i_pc              (pc),
    .o_alloc_ready     (alloc_ready),
    .o_alloc_tag       (alloc_tag),
    .i_cdb_valid       (cdb_valid),
    .i_cdb_tag         (cdb_tag),
`ifdef ROB_EXCEPTION_EN
    .i_cdb_exc         (cdb_exc),
    .o_exception       (exception),
    .o_exception_pc    (exception_pc),
`endif
    .o_commit_valid    (commit_valid),
    .o_commit_old_preg (commit_old_preg),
    .o_commit_tag      (commit_tag),
    .o_count           (count),
    .i_mispredict      (mispredict),
    .i_mispredict_tag  (mispredict_tag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 2'b00;
    cdb_valid   = 2'b00;
    mispredict  = 1'b0;
  endtask

  // Lane k payload: old_prd = 0x40|tag, pc = 0x1000 + 4*tag.
  task automatic set_alloc(input logic [1:0] v, input logic [1:0] rw, input logic [3:0] t0);
    logic [3:0] t1;
    t1          = t0 + 4'd1;
    alloc_valid = v;
    reg_write   = rw;
    is_branch   = 2'b00;
    old_prd     = {3'b100, t1, 3'b100, t0};
    pc          = {32'h1000 + 32'(t1) * 4, 32'h1000 + 32'(t0) * 4};
  endtask

  task automatic cdb(input logic [1:0] v, input logic [7:0] tags);
    cdb_valid = v;
    cdb_tag   = tags;
  endtask

  initial begin
    idle();
    reg_write = '0; is_branch = '0; old_prd = '0; pc = '0;
    cdb_tag = '0; mispredict_tag = '0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rel_alloc_tag", 32'(alloc_tag), 32'h10);

    // Fill all 16 entries, two per cycle; tag 1 does not write a register.
    for (int c = 0; c < 8; c++) begin
      set_alloc(2'b11, (c == 0) ? 2'b01 : 2'b11, 4'(2 * c));
      #1;
      chk("fill_alloc_tag", 32'(alloc_tag), 32'({4'(2 * c + 1), 4'(2 * c)}));
      chk("fill_count", 32'(count), 32'(2 * c));
      chk("fill_ready", 32'(alloc_ready), 1);
      tick();
    end
    idle();
    #1;
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_count", 32'(count), 16);
    chk("full_commit_valid", 32'(commit_valid), 0);

    // Out-of-order completion: tag 1 first, then tag 0 on both ports.
    cdb(2'b01, 8'h01);
    #1 chk("cdb1_commit_valid", 32'(commit_valid), 0);
    tick();
    cdb(2'b11, 8'h00);
    #1 chk("ooo_commit_valid", 32'(commit_valid), 0);
    tick();
    idle();
    #1;
    chk("c01_valid", 32'(commit_valid), 32'h3);
    chk("c01_tag", 32'(commit_tag), 32'h10);
    chk("c01_old_preg", 32'(commit_old_preg), 32'h0040);
    chk("c01_ready", 32'(alloc_ready), 0);
    tick();
    chk("c01_count", 32'(count), 14);
    chk("c01_ready_after", 32'(alloc_ready), 1);
    chk("c01_next_tag", 32'(commit_tag), 32'h32);

    // Drain to count 8, then commit two while allocating two.
    cdb(2'b11, 8'h32);
    tick();
    cdb(2'b11, 8'h54);
    #1;
    chk("c23_valid", 32'(commit_valid), 32'h3);
    chk("c23_tag", 32'(commit_tag), 32'h32);
    tick();
    chk("drain_count12", 32'(count), 12);
    cdb(2'b11, 8'h76);
    tick();
    cdb(2'b11, 8'h98);
    tick();
    chk("drain_count8", 32'(count), 8);
    cdb(2'b00, 8'h00);
    set_alloc(2'b11, 2'b11, 4'd0);
    #1;
    chk("mix_commit_valid", 32'(commit_valid), 32'h3);
    chk("mix_commit_tag", 32'(commit_tag), 32'h98);
    chk("mix_alloc_tag", 32'(alloc_tag), 32'h10);
    chk("mix_ready", 32'(alloc_ready), 1);
    tick();
    idle();
    #1;
    chk("mix_count", 32'(count), 8);
    chk("mix_tail", 32'(alloc_tag), 32'h32);
    chk("mix_head", 32'(commit_tag), 32'hba);
    chk("mix_after_valid", 32'(commit_valid), 0);

    // Move head to 14 and tail to index 3 (wrapped), then flush after tag 15.
    cdb(2'b11, 8'hba);
    tick();
    cdb(2'b11, 8'hdc);
    tick();
    idle();
    tick();
    chk("h14_count", 32'(count), 4);
    set_alloc(2'b01, 2'b01, 4'd2);
    #1 chk("h14_alloc_tag", 32'(alloc_tag), 32'h32);
    tick();
    idle();
    chk("h14_count5", 32'(count), 5);
    cdb(2'b01, 8'h01);
    tick();
    mispredict = 1'b1;
    mispredict_tag = 4'd15;
    set_alloc(2'b11, 2'b11, 4'd3);
    cdb(2'b01, 8'h02);
    #1;
    chk("mp_commit_valid", 32'(commit_valid), 0);
    chk("mp_count_before", 32'(count), 5);
    tick();
    idle();
    #1;
    chk("mp_count", 32'(count), 2);
    chk("mp_tail", 32'(alloc_tag), 32'h10);
    chk("mp_ready", 32'(alloc_ready), 1);

    // Mispredict on the youngest entry while it commits: tail stays, alloc suppressed.
    cdb(2'b11, 8'hfe);
    tick();
    cdb(2'b00, 8'h00);
    mispredict = 1'b1;
    mispredict_tag = 4'd15;
    set_alloc(2'b11, 2'b11, 4'd0);
    #1;
    chk("mpy_commit_valid", 32'(commit_valid), 32'h3);
    chk("mpy_commit_tag", 32'(commit_tag), 32'hfe);
    tick();
    idle();
    #1;
    chk("mpy_count", 32'(count), 0);
    chk("mpy_tail", 32'(alloc_tag), 32'h10);

    // Commit must stop at the mispredicting branch even if younger entries are done.
    set_alloc(2'b11, 2'b11, 4'd0);
    tick();
    idle();
    cdb(2'b11, 8'h10);
    tick();
    cdb(2'b00, 8'h00);
    mispredict = 1'b1;
    mispredict_tag = 4'd0;
    #1;
    chk("mpo_commit_valid", 32'(commit_valid), 32'h1);
    chk("mpo_commit_tag", 32'(commit_tag), 32'h10);
    tick();
    idle();
    #1;
    chk("mpo_count", 32'(count), 0);
    chk("mpo_tail", 32'(alloc_tag), 32'h21);

    // Asynchronous reset in the middle of traffic.
    set_alloc(2'b11, 2'b11, 4'd1);
    #1 chk("rt_alloc_tag", 32'(alloc_tag), 32'h21);
    tick();
    idle();
    cdb(2'b01, 8'h01);
    tick();
    idle();
    #1;
    chk("rt_commit_valid", 32'(commit_valid), 32'h1);
    chk("rt_count", 32'(count), 2);
    #1 reset = 1'b0;
    #1;
    chk("rt_rst_count", 32'(count), 0);
    chk("rt_rst_commit_valid", 32'(commit_valid), 0);
    chk("rt_rst_ready", 32'(alloc_ready), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rt_rel_alloc_tag", 32'(alloc_tag), 32'h10);
    chk("rt_rel_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
